// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, EX FSM states,
// and the default register-index width.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/hazard_unit_mc_stall_ctrl.sv
// Multi-cycle EX controller: holds EX for MUL_LAT cycles (MUL_LAT-1 stall cycles)
// when a long-latency op enters E. MUL_LAT=1 leaves the FSM permanently idle.
module mc_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic MultiCycE,
    output logic mcStall,
    output logic BusyE
);

    localparam bit             MC_EN    = (MUL_LAT >= 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcStall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MC_EN && MultiCycE) begin
                    mcStall = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mcStall = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    // final EX cycle: release the pipeline
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            mcStall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BusyE = (state_q == BUSY) && !rst;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: EX forwarding, load-use stall, branch
// flush and multi-cycle EX hold. HAZARD_PERF_EN adds stall/flush perf counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  ResultSrcE0,
    input  logic                  PCSrcE,
    input  logic                  MultiCycE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  BusyE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           PerfStallCnt,
    output logic [31:0]           PerfFlushCnt
`endif
);

    logic lwStall;
    logic mcStall;

    // M has priority over W: it holds the younger result for the same register
    function automatic fwd_sel_e fwd_sel(
        input logic                  rs_match_m,
        input logic                  rs_match_w
    );
        if (rs_match_m) return FWD_M;
        if (rs_match_w) return FWD_W;
        return FWD_RF;
    endfunction

    mc_stall_ctrl #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) u_mc_stall_ctrl (
        .clk       (clk),
        .rst       (rst),
        .MultiCycE (MultiCycE),
        .mcStall   (mcStall),
        .BusyE     (BusyE)
    );

    always_comb begin
        lwStall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        if (rst) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else begin
            StallF    = lwStall | mcStall;
            StallD    = lwStall | mcStall;
            StallE    = mcStall;
            FlushM    = mcStall;
            // a held multi-cycle op must not be squashed by a stale PCSrcE
            FlushD    = PCSrcE & !mcStall;
            FlushE    = (lwStall | PCSrcE) & !mcStall;
            ForwardAE = fwd_sel(RegWriteM && (RdM != '0) && (RdM == Rs1E),
                                RegWriteW && (RdW != '0) && (RdW == Rs1E));
            ForwardBE = fwd_sel(RegWriteM && (RdM != '0) && (RdM == Rs2E),
                                RegWriteW && (RdW != '0) && (RdW == Rs2E));
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            PerfStallCnt <= '0;
            PerfFlushCnt <= '0;
        end else begin
            if (StallF) begin
                PerfStallCnt <= PerfStallCnt + 32'd1;
            end
            if (PCSrcE && !mcStall) begin
                PerfFlushCnt <= PerfFlushCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: directed cases then random traffic,
// expected outputs from a cycle-level behavioural model.
module tb_hazard_unit_mc;

    localparam int RW      = 5;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic          rst;
        logic [RW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic          rwm, rww, lde, pc, mce;
    } stim_t;

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        sf, sd, se, fd, fe, fm, busy;
        logic [31:0] psc, pfc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic          RegWriteM = 1'b0, RegWriteW = 1'b0, ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MultiCycE = 1'b0;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE;
    logic [1:0]    ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0]   PerfStallCnt, PerfFlushCnt;
`endif

    hazard_unit_mc #(.REG_ADDR_W(RW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MultiCycE(MultiCycE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BusyE(BusyE)
`ifdef HAZARD_PERF_EN
        , .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cycle  = 0;

    // model state: cycles the current multi-cycle op still occupies EX after this one
    int          ex_left = 0;
    logic [31:0] m_psc = '0, m_pfc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, n_cycle, act, req);
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        logic lw, mc;
        @(posedge clk);
        #1;
        rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
        RdE = s.rde; RdM = s.rdm; RdW = s.rdw; RegWriteM = s.rwm; RegWriteW = s.rww;
        ResultSrcE0 = s.lde; PCSrcE = s.pc; MultiCycE = s.mce;

        e = '0;
        e.psc = m_psc;
        e.pfc = m_pfc;
        mc = 1'b0;
        if (s.rst) begin
            e.fd = 1'b1; e.fe = 1'b1; e.fm = 1'b1;
        end else begin
            if (s.rwm && s.rdm != 0 && s.rdm == s.rs1e)      e.fa = 2'b10;
            else if (s.rww && s.rdw != 0 && s.rdw == s.rs1e) e.fa = 2'b01;
            if (s.rwm && s.rdm != 0 && s.rdm == s.rs2e)      e.fb = 2'b10;
            else if (s.rww && s.rdw != 0 && s.rdw == s.rs2e) e.fb = 2'b01;
            lw     = s.lde && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
            e.busy = (ex_left > 0);
            if (ex_left > 0) mc = (ex_left > 1);
            else             mc = s.mce && (MUL_LAT >= 2);
            e.sf = lw | mc;
            e.sd = lw | mc;
            e.se = mc;
            e.fm = mc;
            e.fd = s.pc && !mc;
            e.fe = (lw || s.pc) && !mc;
        end
        exp_q.push_back(e);

        if (s.rst) begin
            ex_left = 0; m_psc = '0; m_pfc = '0;
        end else begin
            if (ex_left > 0)                          ex_left--;
            else if (s.mce && (MUL_LAT >= 2))         ex_left = MUL_LAT - 1;
            if (e.sf)             m_psc = m_psc + 1;
            if (s.pc && !mc)      m_pfc = m_pfc + 1;
        end
    endtask

    // monitor: the outputs are valid every cycle, compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ForwardAE", 32'(ForwardAE), 32'(e.fa));
                check("ForwardBE", 32'(ForwardBE), 32'(e.fb));
                check("StallF",    32'(StallF),    32'(e.sf));
                check("StallD",    32'(StallD),    32'(e.sd));
                check("StallE",    32'(StallE),    32'(e.se));
                check("FlushD",    32'(FlushD),    32'(e.fd));
                check("FlushE",    32'(FlushE),    32'(e.fe));
                check("FlushM",    32'(FlushM),    32'(e.fm));
                check("BusyE",     32'(BusyE),     32'(e.busy));
`ifdef HAZARD_PERF_EN
                check("PerfStallCnt", PerfStallCnt, e.psc);
                check("PerfFlushCnt", PerfFlushCnt, e.pfc);
`endif
                n_cycle++;
            end
        end
    end

    initial begin
        stim_t s;
        s = '0; s.rst = 1'b1;
        apply(s); apply(s);

        // forwarding, M over W
        s = '0; s.rwm = 1; s.rdm = 5; s.rs1e = 5; s.rww = 1; s.rdw = 5; s.rs2e = 5;
        apply(s);
        s.rdm = 0; s.rs1e = 0;
        apply(s);

        // load-use, then RdE=0 (no stall)
        s = '0; s.lde = 1; s.rde = 7; s.rs2d = 7;
        apply(s);
        s.rde = 0;
        apply(s);

        // multi-cycle op held for MUL_LAT cycles, then idle
        s = '0; s.mce = 1;
        repeat (MUL_LAT) apply(s);
        s = '0; apply(s);

        // branch flush alone, then branch while BUSY with cnt!=0
        s = '0; s.pc = 1; apply(s);
        s = '0; s.mce = 1; apply(s);
        s.pc = 1; apply(s);
        s.pc = 0; apply(s);
        s = '0; apply(s);

        // reset in BUSY with cnt=1, then first cycle after reset
        s = '0; s.mce = 1; apply(s);
        s.rst = 1; apply(s);
        s = '0; apply(s);

        // load-use and branch together
        s = '0; s.lde = 1; s.rde = 3; s.rs1d = 3; s.pc = 1;
        apply(s);

        // four load-use stalls and two branches for the perf counters
        s = '0; s.rst = 1; apply(s);
        repeat (4) begin s = '0; s.lde = 1; s.rde = 9; s.rs1d = 9; apply(s); end
        repeat (2) begin s = '0; s.pc = 1; apply(s); end
        s = '0; apply(s);
        s.rst = 1; apply(s);
        s = '0; apply(s);

        // random traffic over a small register range to provoke matches
        for (int i = 0; i < 600; i++) begin
            s.rst  = ($urandom_range(0, 49) == 0);
            s.rs1d = RW'($urandom_range(0, 3)); s.rs2d = RW'($urandom_range(0, 3));
            s.rs1e = RW'($urandom_range(0, 3)); s.rs2e = RW'($urandom_range(0, 3));
            s.rde  = RW'($urandom_range(0, 3)); s.rdm  = RW'($urandom_range(0, 3));
            s.rdw  = RW'($urandom_range(0, 3));
            s.rwm  = 1'($urandom); s.rww = 1'($urandom);
            s.lde  = 1'($urandom); s.pc  = ($urandom_range(0, 3) == 0);
            s.mce  = ($urandom_range(0, 4) == 0);
            apply(s);
        end

        begin
            int guard = 0;
            while (exp_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            n_checks++;
            if (exp_q.size() == 0) n_pass++;
            else $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
